// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, 32 steps, then one sign-fix cycle.
module mul_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        HiWre,
  input  logic        LoWre,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic        is_div, neg_q, neg_r, div_zero;
  logic [31:0] a_orig, opnd, acc, q;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (count == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // Signed ops work on magnitudes; the sign is restored in FIX.
  assign a_mag = (Op[0] && SrcA[31]) ? -SrcA : SrcA;
  assign b_mag = (Op[0] && SrcB[31]) ? -SrcB : SrcB;

  // acc:q is the 64-bit product (multiply) or remainder:quotient (divide).
  assign mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {acc, q[31]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign prod      = {acc, q};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quo_fix   = neg_q ? -q : q;
  assign rem_fix   = neg_r ? -acc : acc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count     <= 5'd0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      a_orig    <= 32'd0;
      opnd      <= 32'd0;
      acc       <= 32'd0;
      q         <= 32'd0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWre) HI <= SrcA;
          if (LoWre) LO <= SrcA;
          if (Start) begin
            count    <= 5'd0;
            is_div   <= Op[1];
            neg_q    <= Op[0] & (SrcA[31] ^ SrcB[31]);
            neg_r    <= Op[0] & Op[1] & SrcA[31];
            div_zero <= Op[1] && (SrcB == 32'd0);
            a_orig   <= SrcA;
            opnd     <= b_mag;
            acc      <= 32'd0;
            q        <= a_mag;
          end
        end
        CALC: begin
          count <= count + 5'd1;
          if (is_div) begin
            // Keep the trial subtraction only when it did not borrow.
            if (!div_diff[32]) begin
              acc <= div_diff[31:0];
              q   <= {q[30:0], 1'b1};
            end else begin
              acc <= div_shift[31:0];
              q   <= {q[30:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[32:1];
            q   <= {mul_sum[0], q[31:1]};
          end
        end
        FIX: begin
          Done      <= 1'b1;
          DivByZero <= div_zero;
          if (!is_div) begin
            {HI, LO} <= prod_fix;
          end else if (div_zero) begin
            HI <= a_orig;
            LO <= 32'hFFFF_FFFF;
          end else begin
            HI <= rem_fix;
            LO <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
